// File: rtl/text_line_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module : text_line_writer_pkg
// Brief  : ASCII control codes and FSM state encoding for the line writer.
// Rev    : 1.0
// ============================================================================
package text_line_writer_pkg;

    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_BLANK    = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_COPY  = 2'd3
    } state_t;

endpackage : text_line_writer_pkg
`default_nettype wire

// File: rtl/text_line_writer_char_bank.sv
`default_nettype none
// ============================================================================
// Module : text_line_writer_char_bank
// Brief  : N_CHARS x 8 register file, one synchronous write, one async read.
// Rev    : 1.0
// ============================================================================
module text_line_writer_char_bank #(
    parameter int N_CHARS = 32,
    parameter int AW      = 5
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [N_CHARS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : text_line_writer_char_bank
`default_nettype wire

// File: rtl/text_line_writer.sv
`default_nettype none
// ============================================================================
// Module : text_line_writer
// Brief  : Edits a back line buffer from an ASCII stream and publishes it to
//          the renderer-facing front buffer during vertical blanking.
// Rev    : 1.0
// ============================================================================
module text_line_writer
    import text_line_writer_pkg::*;
#(
    parameter int         N_CHARS = 32,
    parameter int         AW      = 5,
    parameter logic [7:0] BLANK   = CH_BLANK
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          frame_start,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] cursor,
    output logic          commit_pending,
    output logic          wrapped
);

    localparam logic [AW-1:0] c_LAST = AW'(N_CHARS - 1);
    localparam logic [AW-1:0] c_ONE  = AW'(1);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [AW-1:0] r_cursor, w_cursor_nxt;
    logic          r_pending, w_pending_nxt;
    logic          r_wrapped, w_wrapped_nxt;
    logic          r_in_ready;

    logic          w_accept;
    logic          w_front_we, w_back_we;
    logic [AW-1:0] w_front_addr, w_back_addr;
    logic [7:0]    w_front_wdata, w_back_wdata, w_back_rdata;

    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cursor_nxt  = r_cursor;
        w_pending_nxt = r_pending;
        w_wrapped_nxt = r_wrapped;
        w_front_we    = 1'b0;
        w_front_addr  = r_idx;
        w_front_wdata = BLANK;
        w_back_we     = 1'b0;
        w_back_addr   = r_idx;
        w_back_wdata  = BLANK;

        unique case (r_state)
            ST_INIT: begin
                w_front_we = 1'b1;
                w_back_we  = 1'b1;
                w_idx_nxt  = r_idx + c_ONE;
                if (r_idx == c_LAST) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                w_idx_nxt = '0;
                if (w_accept) begin
                    if (in_data >= CH_PRINT_LO && in_data <= CH_PRINT_HI) begin
                        w_back_we    = 1'b1;
                        w_back_addr  = r_cursor;
                        w_back_wdata = in_data;
                        w_cursor_nxt = r_cursor + c_ONE;
                        if (r_cursor == c_LAST) w_wrapped_nxt = 1'b1;
                    end else if (in_data == CH_CR) begin
                        w_cursor_nxt  = '0;
                        w_wrapped_nxt = 1'b0;
                    end else if (in_data == CH_BS) begin
                        if (r_cursor != '0) begin
                            w_cursor_nxt = r_cursor - c_ONE;
                            w_back_we    = 1'b1;
                            w_back_addr  = r_cursor - c_ONE;
                        end
                    end else if (in_data == CH_LF) begin
                        w_pending_nxt = 1'b1;
                    end else if (in_data == CH_FF) begin
                        w_cursor_nxt  = '0;
                        w_wrapped_nxt = 1'b0;
                        w_state_nxt   = ST_CLEAR;
                    end
                end
                // Only an already-pending line publishes; a same-cycle LF waits.
                if (!(w_accept && in_data == CH_FF) && frame_start && r_pending) begin
                    w_state_nxt = ST_COPY;
                end
            end
            ST_CLEAR: begin
                w_back_we = 1'b1;
                w_idx_nxt = r_idx + c_ONE;
                if (r_idx == c_LAST) w_state_nxt = ST_IDLE;
            end
            ST_COPY: begin
                w_front_we    = 1'b1;
                w_front_wdata = w_back_rdata;
                w_idx_nxt     = r_idx + c_ONE;
                if (r_idx == c_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_pending_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_idx      <= '0;
            r_cursor   <= '0;
            r_pending  <= 1'b0;
            r_wrapped  <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cursor   <= w_cursor_nxt;
            r_pending  <= w_pending_nxt;
            r_wrapped  <= w_wrapped_nxt;
            r_in_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    text_line_writer_char_bank #(
        .N_CHARS (N_CHARS),
        .AW      (AW)
    ) u_front (
        .clk     (clk),
        .i_we    (w_front_we),
        .i_waddr (w_front_addr),
        .i_wdata (w_front_wdata),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    text_line_writer_char_bank #(
        .N_CHARS (N_CHARS),
        .AW      (AW)
    ) u_back (
        .clk     (clk),
        .i_we    (w_back_we),
        .i_waddr (w_back_addr),
        .i_wdata (w_back_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_back_rdata)
    );

    assign in_ready       = r_in_ready;
    assign cursor         = r_cursor;
    assign commit_pending = r_pending;
    assign wrapped        = r_wrapped;

endmodule : text_line_writer
`default_nettype wire

// File: tb/tb_text_line_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_text_line_writer
// Brief  : Directed and randomized bench for text_line_writer with a
//          line-level reference model and per-cycle output comparison.
// Rev    : 1.0
// ============================================================================
module tb_text_line_writer;

    localparam int N = 32;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       frame_start;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] cursor;
    logic       commit_pending;
    logic       wrapped;

    int checks = 0;
    int errors = 0;

    text_line_writer dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .frame_start    (frame_start),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .cursor         (cursor),
        .commit_pending (commit_pending),
        .wrapped        (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole-line edits applied at once, busy time as a count.
    byte unsigned m_front [N];
    byte unsigned m_back  [N];
    int           m_cursor;
    bit           m_wrapped, m_pend, m_copy, m_valid;
    int           m_busy;

    initial m_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ff;
        bit pend_old;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_front[k] = 8'h20;
                m_back[k]  = 8'h20;
            end
            m_cursor = 0; m_wrapped = 0; m_pend = 0; m_copy = 0;
            m_busy = N; m_valid = 1'b1;
        end else if (!m_valid) begin
            // DUT not yet reset; nothing to model.
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_copy) begin
                m_pend = 0;
                m_copy = 0;
            end
        end else begin
            ff = 0;
            pend_old = m_pend;
            if (in_valid) begin
                if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                    m_back[m_cursor] = in_data;
                    if (m_cursor == N - 1) m_wrapped = 1;
                    m_cursor = (m_cursor + 1) % N;
                end else if (in_data == 8'h0D) begin
                    m_cursor = 0; m_wrapped = 0;
                end else if (in_data == 8'h08) begin
                    if (m_cursor > 0) begin
                        m_cursor = m_cursor - 1;
                        m_back[m_cursor] = 8'h20;
                    end
                end else if (in_data == 8'h0A) begin
                    m_pend = 1;
                end else if (in_data == 8'h0C) begin
                    for (int k = 0; k < N; k++) m_back[k] = 8'h20;
                    m_cursor = 0; m_wrapped = 0; m_busy = N; ff = 1;
                end
            end
            if (!ff && frame_start && pend_old) begin
                for (int k = 0; k < N; k++) m_front[k] = m_back[k];
                m_busy = N;
                m_copy = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("in_ready", int'(in_ready), int'(m_busy == 0));
            chk("cursor", int'(cursor), m_cursor);
            chk("wrapped", int'(wrapped), int'(m_wrapped));
            chk("commit_pending", int'(commit_pending), int'(m_pend));
            if (m_busy == 0) chk("rd_data", int'(rd_data), int'(m_front[rd_addr]));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        wait_ready(n);
        sync();
        in_valid = 1'b0;
    endtask

    task automatic publish();
        int n;
        frame_start = 1'b1;
        sync();
        frame_start = 1'b0;
        wait_ready(n);
        chk("copy_cycles", n, N + 1);
        sync();
    endtask

    task automatic read_lit(input int a, input int exp);
        sync();
        rd_addr = 5'(a);
        #1;
        chk("lit_rd", int'(rd_data), exp);
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 39);
        if (r < 24) return 8'($urandom_range(8'h20, 8'h7E));
        else if (r < 28) return 8'h0D;
        else if (r < 33) return 8'h0A;
        else if (r < 37) return 8'h08;
        else if (r < 38) return 8'h0C;
        else if (r < 39) return 8'($urandom_range(8'h00, 8'h1F));
        else return 8'($urandom_range(8'h7F, 8'hFF));
    endfunction

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        frame_start = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_ready(n);
        chk("init_latency", n, N + 1);
        for (int a = 0; a < N; a++) read_lit(a, 8'h20);
        chk("lit_cursor_reset", int'(cursor), 0);

        send_byte("H"); send_byte("I"); send_byte(8'h0A);
        chk("lit_pending_set", int'(commit_pending), 1);
        publish();
        read_lit(0, 8'h48); read_lit(1, 8'h49); read_lit(2, 8'h20);
        chk("lit_pending_clr", int'(commit_pending), 0);

        send_byte(8'h0D);
        send_byte("A"); send_byte("B"); send_byte("C");
        send_byte(8'h08); send_byte(8'h08); send_byte("Z"); send_byte(8'h0A);
        publish();
        read_lit(0, 8'h41); read_lit(1, 8'h5A); read_lit(2, 8'h20);
        chk("lit_cursor_az", int'(cursor), 2);

        send_byte(8'h0D);
        for (int i = 0; i < N + 1; i++) send_byte("x");
        chk("lit_cursor_wrap", int'(cursor), 1);
        chk("lit_wrapped_set", int'(wrapped), 1);
        send_byte(8'h0A);
        publish();
        read_lit(0, 8'h78); read_lit(31, 8'h78);
        send_byte(8'h0D);
        chk("lit_cursor_cr", int'(cursor), 0);
        chk("lit_wrapped_clr", int'(wrapped), 0);

        send_byte("Q");
        in_valid = 1'b1; in_data = 8'h0A; frame_start = 1'b1;
        wait_ready(n);
        sync();
        in_valid = 1'b0; frame_start = 1'b0;
        sync(); sync();
        chk("lit_no_copy_ready", int'(in_ready), 1);
        chk("lit_no_copy_pend", int'(commit_pending), 1);
        publish();
        read_lit(0, 8'h51); read_lit(1, 8'h78);

        in_valid = 1'b1; in_data = 8'h0C;
        wait_ready(n);
        sync();
        in_data = 8'h0A;
        wait_ready(n);
        chk("clear_cycles", n, N + 1);
        sync();
        in_valid = 1'b0;
        chk("lit_pending_after_ff", int'(commit_pending), 1);
        publish();
        for (int a = 0; a < N; a++) read_lit(a, 8'h20);

        send_byte("R"); send_byte(8'h0A);
        frame_start = 1'b1;
        sync();
        frame_start = 1'b0;
        repeat (10) sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        wait_ready(n);
        chk("reset_mid_copy_latency", n, N + 1);
        for (int a = 0; a < N; a++) read_lit(a, 8'h20);
        chk("lit_pending_after_reset", int'(commit_pending), 0);

        sync();
        for (int i = 0; i < 3000; i++) begin
            in_valid    = ($urandom_range(0, 9) < 6);
            in_data     = pick_byte();
            frame_start = !in_valid && ($urandom_range(0, 7) == 0);
            rd_addr     = 5'($urandom_range(0, N - 1));
            sync();
        end
        in_valid = 1'b0; frame_start = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_text_line_writer
`default_nettype wire

// File: doc/text_line_writer.md
Name: text_line_writer

Overview:
- Writer side of the character-line buffer that the VGA text renderer reads.
- Accepts an ASCII byte stream over a valid/ready handshake and edits a back buffer at a cursor.
- Publishes the back buffer to a front buffer only during vertical blanking, so the renderer never shows a half-edited line.
- The renderer indexes the front buffer by character column.

Parameters:
- N_CHARS, 32, characters per line; power of two, 8..64.
- AW, 5, index width, equal to log2(N_CHARS).
- BLANK, 8'h20, fill character for reset, clear and backspace.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- in_data  in  8  ASCII byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a byte this cycle.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- rd_addr  in  AW  character column requested by the renderer.
- rd_data  out  8  front-buffer character at rd_addr; combinational.
- cursor  out  AW  next back-buffer write position.
- commit_pending  out  1  a line is waiting to be published.
- wrapped  out  1  sticky; set when the cursor wraps from N_CHARS-1 to 0; cleared by CR or FF.

Behaviour:
- Handshake: a byte transfers on a cycle with in_valid && in_ready. in_ready=1 only in IDLE and is a registered state decode with no combinational path from in_valid.
- States: INIT, IDLE, CLEAR, COPY. A counter idx (AW bits) is used by INIT, CLEAR and COPY.
- Reset:
  - state=INIT, idx=0, cursor=0, commit_pending=0, wrapped=0, in_ready=0.
  - Reset mid-CLEAR or mid-COPY abandons the operation immediately.
- INIT:
  - Writes BLANK to front[idx] and back[idx] each cycle, idx++.
  - After idx=N_CHARS-1, goes to IDLE. in_ready first rises N_CHARS+1 cycles after reset deasserts.
- IDLE, accepted byte b:
  - 0x20..0x7E: back[cursor]<=b. cursor<=cursor+1 mod N_CHARS. If cursor was N_CHARS-1, wrapped<=1.
  - 0x0D (CR): cursor<=0, wrapped<=0.
  - 0x08 (BS): if cursor>0, cursor<=cursor-1 and back[cursor-1]<=BLANK. At cursor=0 the byte is consumed with no effect.
  - 0x0A (LF): commit_pending<=1. No buffer change.
  - 0x0C (FF): cursor<=0, wrapped<=0, go to CLEAR with idx=0.
  - Any other value: consumed, no effect.
- CLEAR:
  - back[idx]<=BLANK each cycle for N_CHARS cycles, then IDLE.
  - commit_pending is unchanged.
- COPY:
  - Entered from IDLE when frame_start=1 && commit_pending=1.
  - front[idx]<=back[idx] for N_CHARS cycles, then IDLE. commit_pending<=0 on the final copy cycle.
- Simultaneous events:
  - An LF accepted in the same cycle as frame_start does not start COPY that cycle; it commits at the next frame_start.
  - frame_start outside IDLE is ignored; pending work waits for a later frame_start.
  - FF followed by LF before frame_start publishes a blank line.
- Byte timing: back-buffer writes are visible one cycle after acceptance. The cursor update also takes one cycle.
- rd_data = front[rd_addr] combinationally. It may change during COPY, which occurs only in blanking when frame_start is driven correctly.
- Width rules: all cursor and idx arithmetic wraps modulo N_CHARS. No other arithmetic.

Decomposition:
- Shared package holds the ASCII constants: CH_CR, CH_LF, CH_BS, CH_FF, CH_BLANK, CH_PRINT_LO=8'h20, CH_PRINT_HI=8'h7E.
- Shared package also holds the state enum {INIT, IDLE, CLEAR, COPY}.
- One natural sub-module: char_bank, an N_CHARS x 8 register file with one synchronous write port and one combinational read port. It is instantiated twice, as front and back.
- Expected size: about 200 lines of RTL.

Test Plan:
- Reset, then wait 32 cycles -> in_ready rises at cycle 33; rd_data=0x20 for all rd_addr; cursor=0.
- Send "HI", LF, then pulse frame_start -> 32 COPY cycles with in_ready=0, then rd_data[0]=0x48, rd_data[1]=0x49, rd_data[2]=0x20; commit_pending=0.
- Send "ABC", BS, BS, "Z", LF, frame_start -> front reads "AZ" followed by blanks; cursor=2.
- Send 33 printable 'x' bytes -> cursor=1 and wrapped=1; back[0]='x'. After CR -> cursor=0, wrapped=0.
- Send "Q", then LF in the same cycle as frame_start -> no COPY that cycle; the next frame_start publishes 'Q' at column 0.
- Send FF with in_valid held high -> in_ready=0 for 32 cycles. Then LF and frame_start give an all-blank front. Asserting reset mid-COPY returns to INIT and reads all blanks afterwards.
